// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : edge_event_arbiter
// Brief    : Per-channel synchronizer + dual-edge detector feeding pending
//            event slots, drained round-robin onto one valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module edge_event_arbiter #(
  parameter  int NUM_CH      = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int CH_W        = $clog2(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic [NUM_CH-1:0] signal_i,
  output logic              event_valid_o,
  input  logic              event_ready_i,
  output logic [CH_W-1:0]   event_ch_o,
  output logic              event_rise_o,
  output logic [NUM_CH-1:0] overflow_o,
  input  logic              overflow_clr_i
);

  localparam logic [0:0] ST_EMPTY   = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  logic [NUM_CH-1:0] sync_out;
  logic [NUM_CH-1:0] prev_q;
  logic [NUM_CH-1:0] edge_det;

  logic [NUM_CH-1:0] pend_v_q, pend_v_d;
  logic [NUM_CH-1:0] pend_r_q, pend_r_d;
  logic [NUM_CH-1:0] overflow_q, overflow_d;
  logic [NUM_CH-1:0] ovf_set;

  logic [0:0]        state_q, state_d;
  logic [CH_W-1:0]   ptr_q;
  logic [CH_W-1:0]   ch_q;
  logic              rise_q;

  logic              load;
  logic              grant;
  logic              pick_found;
  logic [CH_W-1:0]   pick_ch;
  logic [CH_W-1:0]   cand_ch;
  logic [NUM_CH-1:0] grant_oh;

  // One synchronizer chain per channel; the oldest stage feeds the detector.
  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
      logic [SYNC_STAGES-1:0] chain_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          chain_q <= '0;
        end else begin
          chain_q <= {chain_q[SYNC_STAGES-2:0], signal_i[c]};
        end
      end

      assign sync_out[c] = chain_q[SYNC_STAGES-1];
    end
  endgenerate

  // prev tracks the synchronized level even while disabled, so re-enabling
  // on a steady level never produces a spurious edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= '0;
    end else begin
      prev_q <= sync_out;
    end
  end

  assign edge_det = enable_i ? (sync_out ^ prev_q) : '0;

  assign load  = (state_q == ST_EMPTY) | event_ready_i;
  assign grant = load & pick_found;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    cand_ch    = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand_ch = CH_W'((int'(ptr_q) + i) % NUM_CH);
      if (!pick_found && pend_v_q[cand_ch]) begin
        pick_found = 1'b1;
        pick_ch    = cand_ch;
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (grant) begin
      grant_oh[pick_ch] = 1'b1;
    end
  end

  // A fresh edge always lands in the slot; it only counts as lost data when
  // the slot still held an event that is not leaving this cycle.
  always_comb begin
    pend_v_d = pend_v_q;
    pend_r_d = pend_r_q;
    ovf_set  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (edge_det[c]) begin
        pend_v_d[c] = 1'b1;
        pend_r_d[c] = sync_out[c];
        ovf_set[c]  = pend_v_q[c] & ~grant_oh[c];
      end else if (grant_oh[c]) begin
        pend_v_d[c] = 1'b0;
      end
    end
  end

  assign overflow_d = (overflow_q & {NUM_CH{~overflow_clr_i}}) | ovf_set;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_v_q   <= '0;
      pend_r_q   <= '0;
      overflow_q <= '0;
    end else begin
      pend_v_q   <= pend_v_d;
      pend_r_q   <= pend_r_d;
      overflow_q <= overflow_d;
    end
  end

  // Presented channel/type and pointer only move on a grant, so they hold
  // steady under backpressure and keep their last value when empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= CH_W'(NUM_CH - 1);
      ch_q   <= '0;
      rise_q <= 1'b0;
    end else if (grant) begin
      ptr_q  <= pick_ch;
      ch_q   <= pick_ch;
      rise_q <= pend_r_q[pick_ch];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = pick_found ? ST_PRESENT : ST_EMPTY;
    end
  end

  always_comb begin
    event_valid_o = (state_q == ST_PRESENT);
    event_ch_o    = ch_q;
    event_rise_o  = rise_q;
    overflow_o    = overflow_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// Bench for edge_event_arbiter: directed scenarios plus random traffic,
// all compared every cycle against an event-level reference model.
module tb_edge_event_arbiter;

  localparam int NUM_CH      = 4;
  localparam int SYNC_STAGES = 2;
  localparam int CH_W        = $clog2(NUM_CH);
  localparam int VW          = NUM_CH + CH_W + 2;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              enable_i;
  logic [NUM_CH-1:0] signal_i;
  logic              event_valid_o;
  logic              event_ready_i;
  logic [CH_W-1:0]   event_ch_o;
  logic              event_rise_o;
  logic [NUM_CH-1:0] overflow_o;
  logic              overflow_clr_i;

  always #5 clk_i = ~clk_i;

  edge_event_arbiter #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .enable_i       (enable_i),
    .signal_i       (signal_i),
    .event_valid_o  (event_valid_o),
    .event_ready_i  (event_ready_i),
    .event_ch_o     (event_ch_o),
    .event_rise_o   (event_rise_o),
    .overflow_o     (overflow_o),
    .overflow_clr_i (overflow_clr_i)
  );

  logic [VW-1:0] obs;
  assign obs = {event_valid_o, event_ch_o, event_rise_o, overflow_o};

  int nvec  = 0;
  int nfail = 0;

  // Reference model: input history queue models synchronizer delay,
  // pending slots are plain arrays, arbitration is a modulo search.
  logic [NUM_CH-1:0] m_hist[$];
  logic [NUM_CH-1:0] m_prev, m_pv, m_pr, m_ovf;
  logic              m_valid, m_rise;
  int                m_ch, m_ptr;

  function automatic void m_reset();
    m_hist.delete();
    for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back('0);
    m_prev = '0; m_pv = '0; m_pr = '0; m_ovf = '0;
    m_valid = 1'b0; m_rise = 1'b0; m_ch = 0; m_ptr = NUM_CH - 1;
  endfunction

  function automatic void m_step();
    logic [NUM_CH-1:0] s, ed;
    int g;
    if (!rst_ni) begin
      m_reset();
      return;
    end
    s  = m_hist[SYNC_STAGES-1];
    ed = enable_i ? (s ^ m_prev) : '0;
    if (!m_valid || event_ready_i) begin
      g = -1;
      for (int k = 1; k <= NUM_CH; k++)
        if (g < 0 && m_pv[(m_ptr + k) % NUM_CH]) g = (m_ptr + k) % NUM_CH;
      if (g >= 0) begin
        m_valid = 1'b1; m_ch = g; m_rise = m_pr[g]; m_pv[g] = 1'b0; m_ptr = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (overflow_clr_i) m_ovf = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ed[c]) begin
        if (m_pv[c]) m_ovf[c] = 1'b1;
        m_pv[c] = 1'b1;
        m_pr[c] = s[c];
      end
    end
    m_prev = s;
    m_hist.push_front(signal_i);
    void'(m_hist.pop_back());
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_valid, CH_W'(m_ch), m_rise, m_ovf};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    m_step();
    @(negedge clk_i);
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    m_reset();
    signal_i = '0; enable_i = 1'b1; event_ready_i = 1'b1; overflow_clr_i = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++;
      if (obs !== '0) begin
        nfail++; $display("FAIL reset_state: got %b expected %b", obs, {VW{1'b0}});
      end
    end
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++;
      if (obs !== exp_vec()) begin
        nfail++; $display("FAIL reset_release: got %b expected %b", obs, exp_vec());
      end
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    signal_i = 4'hF;
    for (int i = 1; i <= 8; i++) begin
      tick();
      nvec++;
      if (obs !== exp_vec()) begin
        nfail++; $display("FAIL simul_model cyc %0d: got %b expected %b", i, obs, exp_vec());
      end
      nvec++;
      if (i >= 4 && i <= 7) begin
        if ({event_valid_o, event_ch_o, event_rise_o} !== {1'b1, CH_W'(i - 4), 1'b1}) begin
          nfail++; $display("FAIL simul_order cyc %0d: got v=%b ch=%0d r=%b expected v=1 ch=%0d r=1",
                            i, event_valid_o, event_ch_o, event_rise_o, i - 4);
        end
      end else if (event_valid_o !== 1'b0) begin
        nfail++; $display("FAIL simul_idle cyc %0d: got valid=%b expected 0", i, event_valid_o);
      end
    end
    signal_i = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      nvec++;
      if (obs !== exp_vec()) begin
        nfail++; $display("FAIL simul_drain: got %b expected %b", obs, exp_vec());
      end
    end
  endtask

  task automatic test_single();
    logic [1:0] pat;
    apply_reset();
    for (int ph = 0; ph < 2; ph++) begin
      signal_i[2] = (ph == 0);
      for (int i = 1; i <= 6; i++) begin
        tick();
        nvec++;
        if (obs !== exp_vec()) begin
          nfail++; $display("FAIL single_model ph%0d cyc %0d: got %b expected %b", ph, i, obs, exp_vec());
        end
        pat = {event_valid_o, (i == 4)};
        nvec++;
        if (pat[1] !== pat[0] || overflow_o !== '0 ||
            (i == 4 && (event_ch_o !== CH_W'(2) || event_rise_o !== (ph == 0)))) begin
          nfail++; $display("FAIL single_latency ph%0d cyc %0d: got v=%b ch=%0d r=%b ovf=%b expected v=%b ch=2 r=%0d ovf=0",
                            ph, i, event_valid_o, event_ch_o, event_rise_o, overflow_o, (i == 4), (ph == 0));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    event_ready_i = 1'b0;
    signal_i = 4'b1010;
    for (int i = 1; i <= 14; i++) begin
      tick();
      nvec++;
      if (obs !== exp_vec()) begin
        nfail++; $display("FAIL bp_model cyc %0d: got %b expected %b", i, obs, exp_vec());
      end
      if (i >= 4) begin
        nvec++;
        if ({event_valid_o, event_ch_o, event_rise_o} !== {1'b1, CH_W'(1), 1'b1}) begin
          nfail++; $display("FAIL bp_hold cyc %0d: got v=%b ch=%0d r=%b expected v=1 ch=1 r=1",
                            i, event_valid_o, event_ch_o, event_rise_o);
        end
      end
    end
    event_ready_i = 1'b1;
    tick();
    nvec++;
    if ({event_valid_o, event_ch_o, event_rise_o} !== {1'b1, CH_W'(3), 1'b1}) begin
      nfail++; $display("FAIL bp_next: got v=%b ch=%0d r=%b expected v=1 ch=3 r=1",
                        event_valid_o, event_ch_o, event_rise_o);
    end
    tick();
    nvec++;
    if (event_valid_o !== 1'b0) begin
      nfail++; $display("FAIL bp_empty: got valid=%b expected 0", event_valid_o);
    end
    signal_i = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      nvec++;
      if (obs !== exp_vec()) begin
        nfail++; $display("FAIL bp_drain: got %b expected %b", obs, exp_vec());
      end
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    event_ready_i = 1'b0;
    for (int ph = 0; ph < 3; ph++) begin
      signal_i[0] = (ph != 1);
      for (int i = 0; i < 4; i++) begin
        tick();
        nvec++;
        if (obs !== exp_vec()) begin
          nfail++; $display("FAIL ovf_model ph%0d: got %b expected %b", ph, obs, exp_vec());
        end
      end
    end
    nvec++;
    if (overflow_o !== 4'b0001 || event_valid_o !== 1'b1 || event_rise_o !== 1'b1) begin
      nfail++; $display("FAIL ovf_flag: got ovf=%b v=%b r=%b expected ovf=0001 v=1 r=1",
                        overflow_o, event_valid_o, event_rise_o);
    end
    event_ready_i = 1'b1;
    tick();
    nvec++;
    if ({event_valid_o, event_ch_o, event_rise_o} !== {1'b1, CH_W'(0), 1'b1}) begin
      nfail++; $display("FAIL ovf_newest: got v=%b ch=%0d r=%b expected v=1 ch=0 r=1",
                        event_valid_o, event_ch_o, event_rise_o);
    end
    tick();
    overflow_clr_i = 1'b1;
    tick();
    overflow_clr_i = 1'b0;
    nvec++;
    if (overflow_o !== '0) begin
      nfail++; $display("FAIL ovf_clear: got %b expected 0000", overflow_o);
    end
    signal_i = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      nvec++;
      if (obs !== exp_vec()) begin
        nfail++; $display("FAIL ovf_drain: got %b expected %b", obs, exp_vec());
      end
    end
  endtask

  task automatic test_enable();
    apply_reset();
    enable_i = 1'b0;
    for (int t = 0; t < 3; t++) begin
      signal_i[1] = ~signal_i[1];
      for (int i = 0; i < 4; i++) begin
        tick();
        nvec++;
        if (event_valid_o !== 1'b0 || obs !== exp_vec()) begin
          nfail++; $display("FAIL enable_gated: got %b expected %b", obs, exp_vec());
        end
      end
    end
    enable_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      nvec++;
      if (event_valid_o !== 1'b0) begin
        nfail++; $display("FAIL enable_spurious: got valid=%b expected 0", event_valid_o);
      end
    end
    signal_i[1] = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      nvec++;
      if (obs !== exp_vec() || event_valid_o !== (i == 4) ||
          (i == 4 && (event_ch_o !== CH_W'(1) || event_rise_o !== 1'b0))) begin
        nfail++; $display("FAIL enable_fall cyc %0d: got %b expected %b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    event_ready_i = 1'b0;
    signal_i = 4'b0111;
    for (int i = 0; i < 4; i++) tick();
    nvec++;
    if (event_valid_o !== 1'b1 || obs !== exp_vec()) begin
      nfail++; $display("FAIL rstmid_setup: got %b expected %b", obs, exp_vec());
    end
    #2;
    rst_ni = 1'b0;
    m_reset();
    #1;
    nvec++;
    if (obs !== '0) begin
      nfail++; $display("FAIL rstmid_async: got %b expected %b", obs, {VW{1'b0}});
    end
    signal_i = '0;
    event_ready_i = 1'b1;
    tick(); tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      nvec++;
      if (event_valid_o !== 1'b0 || obs !== exp_vec()) begin
        nfail++; $display("FAIL rstmid_quiet: got %b expected %b", obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 2000; i++) begin
      enable_i       = ($urandom % 8) != 0;
      event_ready_i  = (i % 200 < 60) ? (($urandom % 6) == 0) : (($urandom % 3) != 0);
      overflow_clr_i = ($urandom % 25) == 0;
      for (int c = 0; c < NUM_CH; c++)
        if (($urandom % 6) == 0) signal_i[c] = ~signal_i[c];
      tick();
      nvec++;
      if (obs !== exp_vec()) begin
        nfail++; $display("FAIL random cyc %0d: got %b expected %b", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    rst_ni = 1'b0; enable_i = 1'b1; event_ready_i = 1'b1;
    signal_i = '0; overflow_clr_i = 1'b0;
    m_reset();
    test_reset();
    test_simultaneous();
    test_single();
    test_backpressure();
    test_overflow();
    test_enable();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
